// File: rtl/ct_f_spsram_128x104_ctrl.sv
// Request front-end for the 128x104 single-port SRAM: power-on clear, valid/ready
// request port, and a 2-entry credit-protected read-response FIFO.
module ct_f_spsram_128x104_ctrl #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 104,
    parameter int unsigned SLICE_W    = 26
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             req_vld,
    output logic                             req_rdy,
    input  logic                             req_wr,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/SLICE_W-1:0]    req_wmask,
    output logic                             rsp_vld,
    input  logic                             rsp_rdy,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             init_done,
    output logic [ADDR_WIDTH-1:0]            sram_a,
    output logic                             sram_cen,
    output logic                             sram_gwen,
    output logic [DATA_WIDTH-1:0]            sram_wen,
    output logic [DATA_WIDTH-1:0]            sram_d,
    input  logic [DATA_WIDTH-1:0]            sram_q
);

    localparam int unsigned NSLICE = DATA_WIDTH / SLICE_W;

    // StRst is a one-cycle hold after reset so the first clear write lands
    // in the cycle after the first non-reset edge.
    typedef enum logic [1:0] {StRst, StInit, StRun} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic                    rd_inflight_q;
    logic [DATA_WIDTH-1:0]   fifo_mem_q [2];
    logic                    wr_ptr_q, rd_ptr_q;
    logic [1:0]              fifo_cnt_q;

    logic                    clearing, running;
    logic                    accept, rd_acc, wr_acc, wr_any;
    logic                    push, pop;
    logic [2:0]              occ;
    logic [DATA_WIDTH-1:0]   wen_mask;

    // State register and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StRst;
            init_cnt_q    <= '0;
            rd_inflight_q <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            rd_inflight_q <= rd_acc;
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= sram_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        init_cnt_d = '0;
        unique case (state_q)
            StRst:  state_d = StInit;
            StInit: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) begin
                    state_d = StRun;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StRst;
        endcase
    end

    // Outputs; RST gates everything so no SRAM access happens in a reset cycle.
    always_comb begin
        clearing  = !RST && (state_q == StInit);
        running   = !RST && (state_q == StRun);
        init_done = (state_q == StRun);

        rsp_vld  = (fifo_cnt_q != 2'd0);
        rsp_data = fifo_mem_q[rd_ptr_q];
        pop      = rsp_vld && rsp_rdy;
        push     = rd_inflight_q;

        occ     = 3'(fifo_cnt_q) + 3'(rd_inflight_q) - 3'(pop);
        req_rdy = running && (occ < 3'd2);

        accept = req_vld && req_rdy;
        rd_acc = accept && !req_wr;
        wr_acc = accept && req_wr;
        wr_any = wr_acc && (|req_wmask);

        wen_mask = '1;
        for (int i = 0; i < int'(NSLICE); i++) begin
            wen_mask[i*SLICE_W +: SLICE_W] = {SLICE_W{~req_wmask[i]}};
        end

        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (clearing) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = init_cnt_q;
        end else if (running) begin
            sram_a = req_addr;
            sram_d = req_wdata;
            if (rd_acc) begin
                sram_cen = 1'b0;
            end else if (wr_any) begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = wen_mask;
            end
        end
    end

endmodule

// File: tb/tb_ct_f_spsram_128x104_ctrl.sv
// Directed bench for ct_f_spsram_128x104_ctrl with a behavioural 128x104 SRAM
// attached to the pin side.
module tb_ct_f_spsram_128x104_ctrl;

    localparam logic [103:0] D5   = 104'h0123456789ABCDEF0123456789;
    localparam logic [103:0] ONES = {104{1'b1}};
    localparam logic [103:0] EXP3 = {26'h3ffffff, 26'h0, 26'h3ffffff, 26'h0};

    logic         clk = 1'b0;
    logic         rst;
    logic         req_vld, req_rdy, req_wr;
    logic [6:0]   req_addr;
    logic [103:0] req_wdata;
    logic [3:0]   req_wmask;
    logic         rsp_vld, rsp_rdy;
    logic [103:0] rsp_data;
    logic         init_done;
    logic [6:0]   sram_a;
    logic         sram_cen, sram_gwen;
    logic [103:0] sram_wen, sram_d, sram_q;

    int n_assert = 0;
    int n_fail   = 0;
    int outst    = 0;
    logic acc_s = 1'b0, pop_s = 1'b0;

    logic [103:0] mem [128];

    always #5 clk = ~clk;

    ct_f_spsram_128x104_ctrl dut (
        .CLK       (clk),
        .RST       (rst),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_data  (rsp_data),
        .init_done (init_done),
        .sram_a    (sram_a),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    // Behavioural SRAM: registered Q, bitwise active-low write enables.
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (sram_gwen) sram_q <= mem[sram_a];
            else mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
        end
    end

    // Outstanding reads (accepted, not yet popped) must never exceed FIFO depth.
    always @(negedge clk) begin
        acc_s = req_vld && req_rdy && !req_wr;
        pop_s = rsp_vld && rsp_rdy;
        if (rst === 1'b0) begin
            n_assert++;
            assert (outst <= 2) else begin
                n_fail++;
                $error("FAIL overflow: observed %0d outstanding, expected <= 2", outst);
            end
        end
    end

    always @(posedge clk) begin
        if (rst) outst <= 0;
        else     outst <= outst + int'(acc_s) - int'(pop_s);
    end

    task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [6:0] a,
                         input logic [103:0] d, input logic [3:0] m);
        req_vld   = v;
        req_wr    = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 7'd0, '0, 4'h0);
    endtask

    // Checks n consecutive clear writes starting at address 0.
    task automatic clear_seq(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("clear", {sram_cen, sram_gwen, sram_wen == '0, sram_d == '0, init_done, sram_a},
                {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'(i)});
        end
    endtask

    task automatic done_check();
        @(negedge clk);
        chk("init_done", init_done, 1'b1);
        chk("rdy_after_init", req_rdy, 1'b1);
    endtask

    function automatic logic [103:0] pat(input int k);
        logic [7:0] b;
        b = 8'(k) ^ 8'h5A;
        return {13{b}};
    endfunction

    initial begin
        rst = 1'b1;
        rsp_rdy = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", req_rdy, 1'b0);
        chk("rst_rsp_vld", rsp_vld, 1'b0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_cen", sram_cen, 1'b1);
        chk("rst_gwen", sram_gwen, 1'b1);
        chk("rst_wen", sram_wen, ONES);
        chk("rst_a", sram_a, '0);
        chk("rst_d", sram_d, '0);

        // Power-on clear
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("pre_clear_cen", sram_cen, 1'b1);
        clear_seq(128);
        done_check();

        // Read of a cleared address
        tick(); drive(1'b1, 1'b0, 7'd77, '0, 4'h0);
        @(negedge clk);
        chk("rd77_strobe", {sram_cen, sram_gwen, sram_wen == ONES, sram_a},
            {1'b0, 1'b1, 1'b1, 7'd77});
        tick(); idle();
        @(negedge clk); chk("rd77_n1_vld", rsp_vld, 1'b0);
        tick();
        @(negedge clk); chk("rd77_vld", rsp_vld, 1'b1); chk("rd77_data", rsp_data, '0);
        tick();
        @(negedge clk); chk("rd77_popped", rsp_vld, 1'b0);

        // Full write then immediate read-back
        tick(); drive(1'b1, 1'b1, 7'd5, D5, 4'hF);
        @(negedge clk);
        chk("wr5_pins", {sram_cen, sram_gwen, sram_wen == '0}, {1'b0, 1'b0, 1'b1});
        chk("wr5_d", sram_d, D5);
        tick(); drive(1'b1, 1'b0, 7'd5, '0, 4'h0);
        @(negedge clk); chk("rd5_cen", {sram_cen, sram_gwen}, {1'b0, 1'b1});
        tick(); idle();
        tick();
        @(negedge clk); chk("rd5_vld", rsp_vld, 1'b1); chk("rd5_data", rsp_data, D5);

        // Partial-mask write, then a zero-mask write that must not touch the SRAM
        tick(); drive(1'b1, 1'b1, 7'd9, ONES, 4'hF);
        tick(); drive(1'b1, 1'b1, 7'd9, '0, 4'h5);
        @(negedge clk); chk("wr9_wen", sram_wen, EXP3);
        tick(); drive(1'b1, 1'b1, 7'd9, ONES, 4'h0);
        @(negedge clk); chk("wr9_mask0", {sram_cen, req_rdy}, {1'b1, 1'b1});
        tick(); drive(1'b1, 1'b0, 7'd9, '0, 4'h0);
        tick(); idle();
        tick();
        @(negedge clk); chk("rd9_data", rsp_data, EXP3);

        // Backpressure: two reads accepted, third blocked until a pop
        tick(); rsp_rdy = 1'b0; drive(1'b1, 1'b0, 7'd5, '0, 4'h0);
        @(negedge clk); chk("bp_rdy1", req_rdy, 1'b1);
        tick(); drive(1'b1, 1'b0, 7'd9, '0, 4'h0);
        @(negedge clk); chk("bp_rdy2", req_rdy, 1'b1);
        tick(); drive(1'b1, 1'b0, 7'd77, '0, 4'h0);
        @(negedge clk); chk("bp_rdy3", {req_rdy, sram_cen}, {1'b0, 1'b1});
        tick();
        @(negedge clk);
        chk("bp_full_rdy", req_rdy, 1'b0);
        chk("bp_head", {rsp_vld, rsp_data}, {1'b1, D5});
        tick();
        @(negedge clk); chk("bp_hold", rsp_data, D5);
        tick(); rsp_rdy = 1'b1;
        @(negedge clk);
        chk("bp_release", {req_rdy, sram_cen, sram_a}, {1'b1, 1'b0, 7'd77});
        chk("bp_pop1", rsp_data, D5);
        tick(); idle();
        @(negedge clk); chk("bp_pop2", {rsp_vld, rsp_data}, {1'b1, EXP3});
        tick();
        @(negedge clk); chk("bp_pop3", {rsp_vld, rsp_data}, {1'b1, 104'h0});
        tick();
        @(negedge clk); chk("bp_empty", rsp_vld, 1'b0);

        // Streaming: fill 0..63 then read back one per cycle
        for (int k = 0; k < 64; k++) begin
            tick(); drive(1'b1, 1'b1, 7'(k), pat(k), 4'hF);
        end
        for (int k = 0; k < 66; k++) begin
            tick();
            if (k < 64) drive(1'b1, 1'b0, 7'(k), '0, 4'h0);
            else idle();
            @(negedge clk);
            if (k < 64) chk("stream_rdy", req_rdy, 1'b1);
            if (k >= 2) chk("stream_data", {rsp_vld, rsp_data}, {1'b1, pat(k - 2)});
        end
        tick(); idle();
        @(negedge clk); chk("stream_drained", rsp_vld, 1'b0);

        // Reset with two responses pending
        tick(); rsp_rdy = 1'b0; drive(1'b1, 1'b0, 7'd5, '0, 4'h0);
        tick(); drive(1'b1, 1'b0, 7'd9, '0, 4'h0);
        tick(); idle();
        tick();
        @(negedge clk); chk("pend_vld", rsp_vld, 1'b1);
        tick(); rst = 1'b1;
        @(negedge clk); chk("pend_rst_pins", {sram_cen, req_rdy}, {1'b1, 1'b0});
        tick(); rst = 1'b0; rsp_rdy = 1'b1;
        @(negedge clk);
        chk("pend_flushed", rsp_vld, 1'b0);
        chk("pend_no_write", sram_cen, 1'b1);
        clear_seq(60);

        // Reset again at clear address 60
        tick(); rst = 1'b1;
        @(negedge clk); chk("mid_init_rst_cen", {sram_cen, init_done}, {1'b1, 1'b0});
        tick(); rst = 1'b0;
        @(negedge clk); chk("mid_init_gap", sram_cen, 1'b1);
        clear_seq(128);
        done_check();

        // Data written before reset must be gone
        tick(); drive(1'b1, 1'b0, 7'd5, '0, 4'h0);
        tick(); idle();
        tick();
        @(negedge clk); chk("post_rst_rd5", {rsp_vld, rsp_data}, {1'b1, 104'h0});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
